// File: rtl/rx_deframer_pkg.sv
// rx_deframer_pkg: shared state encoding, default frame constants and counter sizing
package rx_deframer_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t HUNT = 2'd1;
  localparam state_t PAYLOAD = 2'd2;
  localparam logic [15:0] SYNC_WORD_DEF = 16'hA5C3;
  localparam int PAYLOAD_BYTES_DEF = 4;
  function automatic int byte_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/rx_sync_det.sv
// rx_sync_det: sliding 16-bit window over the serial stream, flags a sync-word match
module rx_sync_det #(
  parameter logic [15:0] SYNC_WORD = 16'hA5C3,
  parameter int SYNC_LEN = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic sample_en,
  input  logic rx_din,
  output logic match
);
  localparam logic [15:0] MASK = 16'((32'd1 << SYNC_LEN) - 32'd1);
  localparam logic [4:0] LEN = 5'(SYNC_LEN);
  logic [14:0] sreg;
  logic [15:0] win;
  logic [4:0] cnt;
  assign win = {sreg, rx_din};
  // the counter guarantees SYNC_LEN fresh bits since the last clear
  assign match = sample_en && !clr && cnt >= LEN - 5'd1 && ((win ^ SYNC_WORD) & MASK) == 16'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sreg <= '0;
      cnt <= '0;
    end else if (clr) begin
      sreg <= '0;
      cnt <= '0;
    end else if (sample_en) begin
      sreg <= win[14:0];
      cnt <= cnt == LEN ? cnt : cnt + 5'd1;
    end
endmodule

// File: rtl/rx_deframer.sv
// rx_deframer: hunts a sync word, assembles payload bytes MSB first and checks an additive checksum
module rx_deframer
  import rx_deframer_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int SYNC_LEN = 16,
  parameter int PAYLOAD_BYTES = PAYLOAD_BYTES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rdy_rx,
  input  logic       sample_en,
  input  logic       rx_din,
  output logic       sync_lock,
  output logic [7:0] dout,
  output logic       dout_vld,
  output logic       frame_done,
  output logic       chk_ok,
  output logic       abort
);
  localparam int BW = byte_cnt_w(PAYLOAD_BYTES);
  localparam logic [BW-1:0] LAST = BW'(PAYLOAD_BYTES);
  state_t state;
  logic [2:0] bit_cnt;
  logic [BW-1:0] byte_cnt;
  logic [6:0] part;
  logic [7:0] acc;
  logic [7:0] byte_in;
  logic match;
  assign byte_in = {part, rx_din};
  // detector is held clear outside HUNT so every hunt starts from fresh bits
  rx_sync_det #(.SYNC_WORD(SYNC_WORD), .SYNC_LEN(SYNC_LEN)) u_det (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state != HUNT),
    .sample_en(sample_en),
    .rx_din(rx_din),
    .match(match)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      bit_cnt <= '0;
      byte_cnt <= '0;
      part <= '0;
      acc <= '0;
      sync_lock <= 1'b0;
      dout <= '0;
      dout_vld <= 1'b0;
      frame_done <= 1'b0;
      chk_ok <= 1'b0;
      abort <= 1'b0;
    end else begin
      dout_vld <= 1'b0;
      frame_done <= 1'b0;
      abort <= 1'b0;
      case (state)
        IDLE: if (rdy_rx) state <= HUNT;
        HUNT:
          if (!rdy_rx) state <= IDLE;
          else if (match) begin
            state <= PAYLOAD;
            sync_lock <= 1'b1;
            bit_cnt <= '0;
            byte_cnt <= '0;
            acc <= '0;
          end
        PAYLOAD:
          if (!rdy_rx) begin
            state <= IDLE;
            abort <= 1'b1;
            sync_lock <= 1'b0;
          end else if (sample_en) begin
            part <= byte_in[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7 && byte_cnt == LAST) begin
              frame_done <= 1'b1;
              chk_ok <= byte_in == acc;
              sync_lock <= 1'b0;
              state <= HUNT;
            end else if (bit_cnt == 3'd7) begin
              dout <= byte_in;
              dout_vld <= 1'b1;
              acc <= acc + byte_in;
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_rx_deframer.sv
// tb_rx_deframer: directed frames with hand-computed bytes, checksums and pulse counts
module tb_rx_deframer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy_rx = 1'b0;
  logic sample_en = 1'b0;
  logic rx_din = 1'b0;
  logic sync_lock, dout_vld, frame_done, chk_ok, abort;
  logic [7:0] dout;
  int tests = 0;
  int fails = 0;
  int vld_cnt = 0, fd_cnt = 0, ok_cnt = 0, ab_cnt = 0, rise_cnt = 0;
  logic lock_at_fd = 1'b0;
  logic prev_lock = 1'b0;
  logic [7:0] got[$];

  always #5 clk = ~clk;

  rx_deframer dut (
    .clk(clk),
    .rst_n(rst_n),
    .rdy_rx(rdy_rx),
    .sample_en(sample_en),
    .rx_din(rx_din),
    .sync_lock(sync_lock),
    .dout(dout),
    .dout_vld(dout_vld),
    .frame_done(frame_done),
    .chk_ok(chk_ok),
    .abort(abort)
  );

  always @(negedge clk) begin
    if (dout_vld) begin
      vld_cnt++;
      got.push_back(dout);
    end
    if (frame_done) begin
      fd_cnt++;
      ok_cnt += int'(chk_ok);
      lock_at_fd = sync_lock;
    end
    if (abort) ab_cnt++;
    if (sync_lock && !prev_lock) rise_cnt++;
    prev_lock = sync_lock;
  end

  task automatic clear_mon();
    #1;
    vld_cnt = 0;
    fd_cnt = 0;
    ok_cnt = 0;
    ab_cnt = 0;
    rise_cnt = 0;
    got.delete();
    @(negedge clk);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  // call at a negedge; returns at a negedge
  task automatic send_bits(input logic [63:0] v, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      sample_en = 1'b1;
      rx_din = v[i];
      @(negedge clk);
      sample_en = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #1;
    tests++; if (sync_lock !== 1'b0) begin fails++; $display("FAIL rst_lock got %b want 0", sync_lock); end
    tests++; if (dout !== 8'h00) begin fails++; $display("FAIL rst_dout got %h want 00", dout); end
    tests++; if ({dout_vld, frame_done, chk_ok, abort} !== 4'b0) begin fails++; $display("FAIL rst_pulses got %b want 0000", {dout_vld, frame_done, chk_ok, abort}); end
    @(negedge clk);
    rst_n = 1'b1;
    settle();
    tests++; if ({sync_lock, dout_vld, frame_done, abort} !== 4'b0) begin fails++; $display("FAIL rst_idle got %b want 0000", {sync_lock, dout_vld, frame_done, abort}); end
  endtask

  task automatic test_nominal();
    logic [31:0] cat;
    rdy_rx = 1'b1;
    clear_mon();
    send_bits(64'hA5C3 >> 1, 15, 2);
    tests++; if (sync_lock !== 1'b0) begin fails++; $display("FAIL nom_early_lock got %b want 0", sync_lock); end
    send_bits(64'h1, 1, 2);
    tests++; if (sync_lock !== 1'b1) begin fails++; $display("FAIL nom_lock got %b want 1", sync_lock); end
    send_bits(64'h01020304_0A, 40, 2);
    settle();
    cat = got.size() == 4 ? {got[0], got[1], got[2], got[3]} : 32'h0;
    tests++; if (vld_cnt !== 4) begin fails++; $display("FAIL nom_vld got %0d want 4", vld_cnt); end
    tests++; if (cat !== 32'h01020304) begin fails++; $display("FAIL nom_bytes got %h want 01020304", cat); end
    tests++; if (fd_cnt !== 1 || ok_cnt !== 1) begin fails++; $display("FAIL nom_done got fd=%0d ok=%0d want 1 1", fd_cnt, ok_cnt); end
    tests++; if (lock_at_fd !== 1'b0 || sync_lock !== 1'b0) begin fails++; $display("FAIL nom_unlock got %b%b want 00", lock_at_fd, sync_lock); end
    tests++; if (chk_ok !== 1'b1) begin fails++; $display("FAIL nom_chk_hold got %b want 1", chk_ok); end
  endtask

  task automatic test_bad_chk();
    clear_mon();
    send_bits(64'hA5C3, 16, 2);
    send_bits(64'h01020304_0B, 40, 2);
    settle();
    tests++; if (vld_cnt !== 4) begin fails++; $display("FAIL bad_vld got %0d want 4", vld_cnt); end
    tests++; if (fd_cnt !== 1 || ok_cnt !== 0) begin fails++; $display("FAIL bad_done got fd=%0d ok=%0d want 1 0", fd_cnt, ok_cnt); end
    tests++; if (chk_ok !== 1'b0) begin fails++; $display("FAIL bad_chk_hold got %b want 0", chk_ok); end
  endtask

  task automatic test_rdy_low();
    logic [31:0] cat;
    rdy_rx = 1'b0;
    clear_mon();
    send_bits(64'hA5C3, 16, 2);
    send_bits(64'h01020304_0A, 40, 2);
    settle();
    tests++; if (rise_cnt !== 0 || vld_cnt !== 0 || fd_cnt !== 0) begin fails++; $display("FAIL rdy_low got rise=%0d vld=%0d fd=%0d want 0 0 0", rise_cnt, vld_cnt, fd_cnt); end
    rdy_rx = 1'b1;
    clear_mon();
    send_bits(64'hA5C3, 16, 2);
    send_bits(64'h01020304_0A, 40, 2);
    settle();
    cat = got.size() == 4 ? {got[0], got[1], got[2], got[3]} : 32'h0;
    tests++; if (cat !== 32'h01020304 || ok_cnt !== 1) begin fails++; $display("FAIL rdy_resume got %h ok=%0d want 01020304 1", cat, ok_cnt); end
  endtask

  task automatic test_abort();
    logic [31:0] cat;
    clear_mon();
    send_bits(64'hA5C3, 16, 2);
    send_bits(64'h0102, 16, 2);
    send_bits(64'h0, 3, 2);
    rdy_rx = 1'b0;
    send_bits(64'h03, 5, 2);
    send_bits(64'h04_0A, 16, 2);
    settle();
    tests++; if (ab_cnt !== 1) begin fails++; $display("FAIL abort_pulse got %0d want 1", ab_cnt); end
    tests++; if (vld_cnt !== 2 || fd_cnt !== 0) begin fails++; $display("FAIL abort_vld got vld=%0d fd=%0d want 2 0", vld_cnt, fd_cnt); end
    tests++; if (sync_lock !== 1'b0) begin fails++; $display("FAIL abort_lock got %b want 0", sync_lock); end
    rdy_rx = 1'b1;
    clear_mon();
    send_bits(64'hA5C3, 16, 2);
    send_bits(64'h01020304_0A, 40, 2);
    settle();
    cat = got.size() == 4 ? {got[0], got[1], got[2], got[3]} : 32'h0;
    tests++; if (cat !== 32'h01020304 || ok_cnt !== 1 || ab_cnt !== 0) begin fails++; $display("FAIL abort_resume got %h ok=%0d ab=%0d want 01020304 1 0", cat, ok_cnt, ab_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] c0, c1;
    clear_mon();
    send_bits(64'hA5C3, 16, 1);
    send_bits(64'h01A5C304_6D, 40, 1);
    send_bits(64'hA5C3, 16, 1);
    send_bits(64'h01A5C304_6D, 40, 1);
    settle();
    c0 = got.size() == 8 ? {got[0], got[1], got[2], got[3]} : 32'h0;
    c1 = got.size() == 8 ? {got[4], got[5], got[6], got[7]} : 32'h0;
    tests++; if (vld_cnt !== 8) begin fails++; $display("FAIL b2b_vld got %0d want 8", vld_cnt); end
    tests++; if (c0 !== 32'h01A5C304 || c1 !== 32'h01A5C304) begin fails++; $display("FAIL b2b_bytes got %h %h want 01a5c304 x2", c0, c1); end
    tests++; if (fd_cnt !== 2 || ok_cnt !== 2) begin fails++; $display("FAIL b2b_done got fd=%0d ok=%0d want 2 2", fd_cnt, ok_cnt); end
    tests++; if (rise_cnt !== 2) begin fails++; $display("FAIL b2b_locks got %0d want 2", rise_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] cat;
    clear_mon();
    send_bits(64'hA5C3, 16, 2);
    send_bits(64'h01, 8, 2);
    send_bits(64'h0, 3, 2);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (sync_lock !== 1'b0 || dout !== 8'h00 || chk_ok !== 1'b0) begin fails++; $display("FAIL rstmid_async got lock=%b dout=%h chk=%b want 0 00 0", sync_lock, dout, chk_ok); end
    @(negedge clk);
    rst_n = 1'b1;
    settle();
    tests++; if (ab_cnt !== 0) begin fails++; $display("FAIL rstmid_abort got %0d want 0", ab_cnt); end
    clear_mon();
    send_bits(64'hA5C3, 16, 2);
    send_bits(64'h01020304_0A, 40, 2);
    settle();
    cat = got.size() == 4 ? {got[0], got[1], got[2], got[3]} : 32'h0;
    tests++; if (cat !== 32'h01020304 || ok_cnt !== 1) begin fails++; $display("FAIL rstmid_resume got %h ok=%0d want 01020304 1", cat, ok_cnt); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_nominal();
    test_bad_chk();
    test_rdy_low();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
